// File: rtl/serial_rx_3_pkg.sv
// Shared definitions for the serial_rx_3 receiver: FSM state encodings,
// default frame width and the bit-counter width helper.
// No ports; imported by the RTL and the testbench.
package serial_rx_3_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // ceil(log2(w)) bits index the data bits; kept at least one bit wide so
    // a single-bit frame still has a legal counter vector.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_rx_3_if.sv
// Serial receive bundle for serial_rx_3.
// Ports (signals):
//   sin       - serial line (idle 0, start 1, data LSB first, stop 0)
//   data      - last correctly framed word
//   valid     - one-cycle pulse, data updated this cycle
//   frame_err - one-cycle pulse, stop bit was 1
//   any       - OR-reduction of data
//   busy      - frame reception in progress
// Modports: master drives sin (line side), slave is the receiver.
interface serial_rx_3_if #(
    parameter int unsigned WIDTH = 3
);

    logic             sin;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             frame_err;
    logic             any;
    logic             busy;

    modport master (
        output sin,
        input  data, valid, frame_err, any, busy
    );

    modport slave (
        input  sin,
        output data, valid, frame_err, any, busy
    );

endinterface

// File: rtl/serial_rx_3_shift_reg_in.sv
// shift_reg_in: WIDTH-bit serial-in/parallel-out capture register.
// Ports:
//   clk  - clock
//   clr  - synchronous clear (highest priority)
//   en   - capture enable
//   sin  - serial bit to store
//   idx  - bit position written when en is high
//   q    - parallel contents
module shift_reg_in #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    input  logic [CNT_W-1:0] idx,
    output logic [WIDTH-1:0] q
);

    // Indexed write keeps LSB-first order without a physical shift chain.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (idx == CNT_W'(i)) begin
                    q[i] <= sin;
                end
            end
        end
    end

endmodule

// File: rtl/serial_rx_3.sv
// serial_rx_3: framed serial receiver (start 1, WIDTH data bits LSB first,
// stop 0).
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   rx    - serial_rx_3_if.slave (sin in; data/valid/frame_err/any/busy out)
// valid/frame_err rise WIDTH+2 edges after the start-bit edge: the stop-bit
// verdict is staged one cycle before being published.
module serial_rx_3
    import serial_rx_3_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    serial_rx_3_if.slave rx
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic             pend_ok_q;
    logic             pend_err_q;
    logic             valid_q;
    logic             err_q;

    logic             shift_clr_c;
    logic             shift_en_c;
    logic             cnt_clr_c;
    logic             cnt_inc_c;
    logic             stop_ok_c;
    logic             stop_err_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rx.sin) state_nxt = ST_DATA;
            ST_DATA: if (cnt_q == CNT_LAST) state_nxt = ST_STOP;
            ST_STOP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        shift_clr_c = 1'b0;
        shift_en_c  = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_inc_c   = 1'b0;
        stop_ok_c   = 1'b0;
        stop_err_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                shift_clr_c = rx.sin;
                cnt_clr_c   = rx.sin;
            end
            ST_DATA: begin
                shift_en_c = 1'b1;
                cnt_inc_c  = (cnt_q != CNT_LAST);
            end
            ST_STOP: begin
                stop_ok_c  = ~rx.sin;
                stop_err_c = rx.sin;
            end
            default: begin
            end
        endcase
    end

    // Data bit index.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr_c) begin
            cnt_q <= '0;
        end else if (cnt_inc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    shift_reg_in #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk (clk),
        .clr (reset | shift_clr_c),
        .en  (shift_en_c),
        .sin (rx.sin),
        .idx (cnt_q),
        .q   (shift_q)
    );

    // Output registers. shift_q still holds the finished frame on the
    // publish edge even if a new start bit clears it on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_ok_q  <= 1'b0;
            pend_err_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            pend_ok_q  <= stop_ok_c;
            pend_err_q <= stop_err_c;
            valid_q    <= pend_ok_q;
            err_q      <= pend_err_q;
            if (pend_ok_q) begin
                data_q <= shift_q;
            end
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = err_q;
    assign rx.any       = |data_q;
    assign rx.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_3.sv
// Directed testbench for serial_rx_3 (WIDTH = 3).
// No ports; drives the line through serial_rx_3_if and checks outputs
// 1 time unit after each rising edge.
module tb_serial_rx_3;
    import serial_rx_3_pkg::*;

    localparam int unsigned W = DEF_WIDTH;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    serial_rx_3_if #(.WIDTH(W)) rx_if ();

    serial_rx_3 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    always #5 clk = ~clk;

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start, WIDTH data bits (LSB first) and stop on consecutive
    // edges. Reports outputs seen after the start edge and how many
    // valid/frame_err pulses appeared on the remaining edges of the frame.
    task automatic send_frame(input logic [W-1:0] bits, input logic stop,
                              output logic v0, output logic e0,
                              output logic [W-1:0] d0, output int late);
        late = 0;
        rx_if.sin = 1'b1;
        tick();
        v0 = rx_if.valid;
        e0 = rx_if.frame_err;
        d0 = rx_if.data;
        for (int i = 0; i < int'(W); i++) begin
            rx_if.sin = bits[i];
            tick();
            if (rx_if.valid || rx_if.frame_err) late++;
        end
        rx_if.sin = stop;
        tick();
        if (rx_if.valid || rx_if.frame_err) late++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_if.sin = 1'b1;
        tick();
        tick();
        checks++; if (rx_if.data !== 3'b000) begin errors++; $display("FAIL reset_data: got %b expected 000", rx_if.data); end
        checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.valid); end
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rx_if.frame_err); end
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_if.busy); end
        checks++; if (rx_if.any !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", rx_if.any); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); end
        reset = 1'b0;
        rx_if.sin = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({rx_if.valid, rx_if.busy, rx_if.any, rx_if.data} !== 6'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: got v=%b busy=%b any=%b data=%b expected all 0",
                         c, rx_if.valid, rx_if.busy, rx_if.any, rx_if.data);
            end
        end
    endtask

    // Start bit on the first edge after reset release; bits 1,0,1.
    task automatic test_frame_basic();
        logic [W-1:0] bits;
        reset = 1'b1;
        rx_if.sin = 1'b0;
        tick();
        reset = 1'b0;
        rx_if.sin = 1'b1;
        tick();
        checks++; if (rx_if.busy !== 1'b1) begin errors++; $display("FAIL first_start_busy: got %b expected 1", rx_if.busy); end
        checks++; if (dut.state !== ST_DATA) begin errors++; $display("FAIL first_start_state: got %0d expected %0d", dut.state, ST_DATA); end
        bits = 3'b101;
        for (int i = 0; i < int'(W); i++) begin
            rx_if.sin = bits[i];
            tick();
        end
        checks++; if (dut.state !== ST_STOP) begin errors++; $display("FAIL basic_stop_state: got %0d expected %0d", dut.state, ST_STOP); end
        rx_if.sin = 1'b0;
        tick();
        checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", rx_if.valid); end
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_stop: got %b expected 0", rx_if.busy); end
        tick();
        checks++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b101) begin errors++; $display("FAIL basic_data: got %b expected 101", rx_if.data); end
        checks++; if (rx_if.any !== 1'b1) begin errors++; $display("FAIL basic_any: got %b expected 1", rx_if.any); end
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", rx_if.frame_err); end
        tick();
        checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width: got %b expected 0", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b101) begin errors++; $display("FAIL basic_data_hold: got %b expected 101", rx_if.data); end
    endtask

    task automatic test_frame_err();
        logic         v0, e0;
        logic [W-1:0] d0;
        int           late;
        send_frame(3'b000, 1'b0, v0, e0, d0, late);
        rx_if.sin = 1'b0;
        tick();
        checks++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b000) begin errors++; $display("FAIL zero_data: got %b expected 000", rx_if.data); end
        checks++; if (rx_if.any !== 1'b0) begin errors++; $display("FAIL zero_any: got %b expected 0", rx_if.any); end
        tick();
        send_frame(3'b011, 1'b1, v0, e0, d0, late);
        checks++; if (late != 0) begin errors++; $display("FAIL err_frame_pulses: got %0d expected 0", late); end
        rx_if.sin = 1'b0;
        tick();
        checks++; if (rx_if.frame_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", rx_if.frame_err); end
        checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL err_no_valid: got %b expected 0", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b000) begin errors++; $display("FAIL err_data_hold: got %b expected 000", rx_if.data); end
        tick();
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", rx_if.frame_err); end
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b expected 0", rx_if.busy); end
    endtask

    // A 1 right after a bad stop bit starts the next frame.
    task automatic test_err_resync();
        logic         v0, e0;
        logic [W-1:0] d0;
        int           late;
        send_frame(3'b010, 1'b1, v0, e0, d0, late);
        send_frame(3'b101, 1'b0, v0, e0, d0, late);
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL resync_err: got %b expected 1", e0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL resync_no_valid: got %b expected 0", v0); end
        checks++; if (d0 !== 3'b000) begin errors++; $display("FAIL resync_data_hold: got %b expected 000", d0); end
        rx_if.sin = 1'b0;
        tick();
        checks++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b expected 1", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b101) begin errors++; $display("FAIL resync_data: got %b expected 101", rx_if.data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic         v0, e0;
        logic [W-1:0] d0;
        int           late;
        send_frame(3'b110, 1'b0, v0, e0, d0, late);
        send_frame(3'b011, 1'b0, v0, e0, d0, late);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", v0); end
        checks++; if (d0 !== 3'b110) begin errors++; $display("FAIL b2b_data1: got %b expected 110", d0); end
        checks++; if (late != 0) begin errors++; $display("FAIL b2b_gap_pulses: got %0d expected 0", late); end
        rx_if.sin = 1'b0;
        tick();
        checks++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b expected 1", rx_if.valid); end
        checks++; if (rx_if.data !== 3'b011) begin errors++; $display("FAIL b2b_data2: got %b expected 011", rx_if.data); end
        tick();
        checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end: got %b expected 0", rx_if.valid); end
    endtask

    // Reset lands on the edge sampling the second data bit of 3'b111.
    task automatic test_reset_mid_frame();
        int pulses;
        rx_if.sin = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", rx_if.busy); end
        checks++; if (rx_if.data !== 3'b000) begin errors++; $display("FAIL mid_data: got %b expected 000", rx_if.data); end
        checks++; if (rx_if.any !== 1'b0) begin errors++; $display("FAIL mid_any: got %b expected 0", rx_if.any); end
        reset = 1'b0;
        rx_if.sin = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rx_if.valid || rx_if.frame_err) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_exhaustive();
        logic         v0, e0;
        logic [W-1:0] d0;
        int           late;
        int           pulses;
        for (int v = 0; v < 8; v++) begin
            send_frame(3'(v), 1'b0, v0, e0, d0, late);
            rx_if.sin = 1'b0;
            pulses = 0;
            for (int g = 0; g < 25; g++) begin
                tick();
                if (g == 0) begin
                    checks++; if (rx_if.valid !== 1'b1) begin errors++; $display("FAIL exh_valid v=%0d: got %b expected 1", v, rx_if.valid); end
                    checks++; if (rx_if.data !== 3'(v)) begin errors++; $display("FAIL exh_data v=%0d: got %b expected %b", v, rx_if.data, 3'(v)); end
                    checks++; if (rx_if.any !== (v != 0)) begin errors++; $display("FAIL exh_any v=%0d: got %b expected %b", v, rx_if.any, (v != 0)); end
                end
                if (rx_if.valid) pulses++;
            end
            checks++; if (pulses != 1 || late != 0) begin errors++; $display("FAIL exh_pulse_count v=%0d: got %0d/%0d expected 1/0", v, pulses, late); end
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_if.sin = 1'b0;
        test_reset();
        test_frame_basic();
        test_frame_err();
        test_err_resync();
        test_back_to_back();
        test_reset_mid_frame();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_rx_3.md
SERIAL_RX_3 -- requirements
Module: serial_rx_3

Interface
REQ-001 Parameter: WIDTH, default 3, number of data bits per frame (legal 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: sin  input  1  serial line; idle level 0, start bit 1, data LSB first, stop bit 0.
REQ-005 Port: data  output  WIDTH  last correctly framed word.
REQ-006 Port: valid  output  1  one-cycle pulse; data updated this cycle.
REQ-007 Port: frame_err  output  1  one-cycle pulse; stop bit was 1.
REQ-008 Port: any  output  1  OR-reduction of data.
REQ-009 Port: busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-010 States SHALL be IDLE, DATA, STOP; a bit counter of ceil(log2(WIDTH)) bits SHALL index DATA bits.
REQ-011 IDLE: sin=1 sampled -> DATA, counter=0; sin=0 -> stay IDLE.
REQ-012 DATA: each cycle, shift sin into bit position counter of an internal shift register; on counter=WIDTH-1 -> STOP, else counter+1.
REQ-013 STOP: sin=0 -> load data from shift register, pulse valid next cycle edge (valid high in the cycle following the stop-bit sample); sin=1 -> pulse frame_err, data unchanged; both -> IDLE.
REQ-014 Latency: valid SHALL rise exactly WIDTH+2 cycles after the edge sampling the start bit.
REQ-015 valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle.
REQ-016 Back-to-back: a start bit sampled in the cycle immediately after STOP SHALL begin a new frame with no lost cycle.
REQ-017 A frame_err SHALL NOT resynchronise beyond returning to IDLE; a 1 on sin in the following cycle is treated as a start bit.
REQ-018 any SHALL be combinational from the data register (any = |data), hence changes only with data.
REQ-019 data SHALL hold its value indefinitely between valid pulses.
REQ-020 busy SHALL be 0 in IDLE and 1 in DATA and STOP.

Reset
REQ-021 reset=1 at an edge SHALL force state=IDLE, counter=0, shift register=0, data=0, valid=0, frame_err=0; hence any=0, busy=0.
REQ-022 Reset mid-frame SHALL abandon the frame with no valid or frame_err pulse; reset SHALL take priority over sin.
REQ-023 First frame after reset deasserts SHALL be accepted if its start bit is sampled on the first edge with reset=0.

Structure
REQ-024 State encodings (IDLE=2'd0, DATA=2'd1, STOP=2'd2) SHALL live in a shared include file of localparams, used by module and bench.
REQ-025 One sub-module, shift_reg_in (WIDTH-bit serial-in/parallel-out with shift enable and synchronous clear), SHALL hold incoming bits; FSM and output registers remain in serial_rx_3.
REQ-026 Estimated RTL size 120-250 lines including sub-module.

Verification
REQ-027 Reset then sin=0 for 10 cycles -> data=000, valid never high, busy=0, any=0.
REQ-028 Frame sin=1,1,0,1,0 (start, bits 1,0,1, stop) -> valid pulse 5 cycles after start edge, data=3'b101, any=1.
REQ-029 Frame start, 0,0,0, stop=0 -> valid pulse, data=3'b000, any=0; then frame with stop=1 and bits 1,1,0 -> frame_err pulse, data stays 000.
REQ-030 Two frames back-to-back (3'b110 then 3'b011, no idle gap) -> two valid pulses exactly 5 cycles apart, data=110 then 011.
REQ-031 Reset asserted during second data bit of a 3'b111 frame -> no valid, no frame_err, data=000, busy=0 next cycle.
REQ-032 Exhaustive: all 8 values of data sent with 25-cycle idle gaps -> each valid pulse shows matching data and any = (data != 0).
